// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory request/ack, redirect
// input and the instruction handoff toward decode.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    modport master (
        output imem_req, imem_addr,
        output instr_valid, instr, instr_pc,
        input  imem_ack, imem_rdata,
        input  redirect_valid, redirect_pc,
        input  instr_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        input  instr_valid, instr, instr_pc,
        output imem_ack, imem_rdata,
        output redirect_valid, redirect_pc,
        output instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, 2-entry {pc, instr}
// buffer toward decode, redirect flush with in-flight data dropping.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DROP
    } state_t;

    state_t      r_state;
    logic        r_req;
    logic [31:0] r_fpc;
    logic [31:0] r_pc  [2];
    logic [31:0] r_ins [2];
    logic        r_head;
    logic [1:0]  r_cnt;

    logic        w_valid;
    logic        w_pop;
    logic        w_push;
    logic        w_redir;
    logic        w_ack;
    logic        w_tail;
    logic [31:0] w_rpc;

    assign w_valid = (r_cnt != 2'd0);
    assign w_pop   = w_valid && bus.instr_ready;
    assign w_redir = bus.redirect_valid;
    assign w_ack   = bus.imem_ack;
    assign w_push  = (r_state == S_WAIT) && w_ack && !w_redir;
    assign w_tail  = r_head ^ r_cnt[0];
    assign w_rpc   = {bus.redirect_pc[31:2], 2'b00};

    // An ack only matters while a request is outstanding (WAIT/DROP).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_fpc   <= {RESET_PC[31:2], 2'b00};
        end else if (w_redir) begin
            r_fpc <= w_rpc;
            if (r_state != S_IDLE && !w_ack) begin
                r_state <= S_DROP;
                r_req   <= 1'b1;
            end else begin
                r_state <= S_IDLE;
                r_req   <= 1'b0;
            end
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (r_cnt != 2'd2) begin
                        r_state <= S_WAIT;
                        r_req   <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (w_ack) begin
                        r_state <= S_IDLE;
                        r_req   <= 1'b0;
                        r_fpc   <= r_fpc + 32'd4;
                    end
                end
                S_DROP: begin
                    if (w_ack) begin
                        r_state <= S_IDLE;
                        r_req   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    // A push only happens with count<2, so the tail slot is always free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head   <= 1'b0;
            r_cnt    <= 2'd0;
            r_pc[0]  <= 32'd0;
            r_pc[1]  <= 32'd0;
            r_ins[0] <= 32'd0;
            r_ins[1] <= 32'd0;
        end else if (w_redir) begin
            r_head <= 1'b0;
            r_cnt  <= 2'd0;
        end else begin
            if (w_push) begin
                r_pc[w_tail]  <= r_fpc;
                r_ins[w_tail] <= bus.imem_rdata;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 2'd1;
            end else if (!w_push && w_pop) begin
                r_cnt <= r_cnt - 2'd1;
            end
        end
    end

    assign bus.imem_req    = r_req;
    assign bus.imem_addr   = r_fpc;
    assign bus.instr_valid = w_valid;
    assign bus.instr       = w_valid ? r_ins[r_head] : 32'd0;
    assign bus.instr_pc    = w_valid ? r_pc[r_head]  : 32'd0;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic
// checked against a queue-based behavioural model.
module tb_fetch_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst_n2 = 1'b0;

    always #5 clk = ~clk;

    fetch_unit_if bus ();
    fetch_unit_if bus2 ();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst_n(rst_n2), .bus(bus2)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word(logic [31:0] a);
        return (a * 32'd3) ^ 32'h1357_9BDF;
    endfunction

    // Model: fetch pc, outstanding flag, drop flag, queue of {pc, instr}.
    logic [31:0] m_pc;
    bit          m_pend;
    bit          m_drop;
    logic [63:0] m_q[$];

    task automatic m_reset();
        m_q.delete();
        m_pc = 32'h0;
        m_pend = 0;
        m_drop = 0;
    endtask

    task automatic m_check(string tag);
        logic [63:0] h;
        h = (m_q.size() != 0) ? m_q[0] : 64'd0;
        chk({tag, ".req"}, 32'(bus.imem_req), 32'(m_pend));
        chk({tag, ".addr"}, bus.imem_addr, m_pc);
        chk({tag, ".valid"}, 32'(bus.instr_valid), 32'(m_q.size() != 0));
        chk({tag, ".instr"}, bus.instr, h[31:0]);
        chk({tag, ".pc"}, bus.instr_pc, h[63:32]);
    endtask

    task automatic m_step();
        bit pop;
        bit issue;
        pop = (m_q.size() != 0) && bus.instr_ready;
        if (bus.redirect_valid) begin
            m_q.delete();
            m_pc = {bus.redirect_pc[31:2], 2'b00};
            if (m_pend && bus.imem_ack) m_pend = 0;
            else if (m_pend) m_drop = 1;
        end else if (!m_pend) begin
            issue = (m_q.size() < 2);
            if (pop) void'(m_q.pop_front());
            if (issue) begin
                m_pend = 1;
                m_drop = 0;
            end
        end else begin
            if (pop) void'(m_q.pop_front());
            if (bus.imem_ack) begin
                if (!m_drop) begin
                    m_q.push_back({m_pc, bus.imem_rdata});
                    m_pc = m_pc + 32'd4;
                end
                m_pend = 0;
            end
        end
    endtask

    // am: 0 no ack, 1 ack whenever req is high, 2 random ack
    task automatic cyc(string tag, bit rv, logic [31:0] rpc, int am, bit rdy);
        @(negedge clk);
        m_check(tag);
        bus.redirect_valid = rv;
        bus.redirect_pc = rpc;
        bus.instr_ready = rdy;
        case (am)
            1: bus.imem_ack = bus.imem_req;
            2: bus.imem_ack = ($urandom_range(0, 99) < 40);
            default: bus.imem_ack = 1'b0;
        endcase
        bus.imem_rdata = (am == 2) ? $urandom : word(bus.imem_addr);
        @(posedge clk);
        m_step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 32'h0;
        bus.instr_ready = 1'b0;
        m_reset();
        @(negedge clk);
        m_check("reset");
        rst_n = 1'b1;
        @(posedge clk);
        m_step();
    endtask

    task automatic d2cyc(bit auto_ack, bit rdy);
        @(negedge clk);
        bus2.instr_ready = rdy;
        bus2.imem_ack = auto_ack && bus2.imem_req;
        bus2.imem_rdata = word(bus2.imem_addr);
        @(posedge clk);
        #1;
    endtask

    logic [31:0] seen[$];
    logic [31:0] got_addr;
    bit found;

    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 32'h0;
        bus.instr_ready = 1'b0;
        bus2.redirect_valid = 1'b0;
        bus2.redirect_pc = 32'h0;
        bus2.imem_ack = 1'b0;
        bus2.imem_rdata = 32'h0;
        bus2.instr_ready = 1'b0;

        // single-cycle ack, decode always ready
        do_reset();
        for (int i = 0; i < 9; i++) begin
            cyc("seq", 0, 32'h0, 1, 1);
            #1;
            if (bus.instr_valid) begin
                seen.push_back(bus.instr_pc);
                chk("seq.word", bus.instr, word(bus.instr_pc));
            end
        end
        chk("seq.n", 32'(seen.size() >= 4), 32'd1);
        for (int i = 0; i < 4 && i < seen.size(); i++)
            chk("seq.pc", seen[i], 32'(i * 4));

        // decode stalled: buffer fills, fetch stops
        do_reset();
        for (int i = 0; i < 8; i++) cyc("full", 0, 32'h0, 1, 0);
        #1;
        chk("full.req", 32'(bus.imem_req), 32'd0);
        chk("full.head", bus.instr_pc, 32'h0);
        found = 0;
        got_addr = 32'h0;
        for (int i = 0; i < 6 && !found; i++) begin
            cyc("drain", 0, 32'h0, 0, 1);
            #1;
            if (bus.imem_req) begin
                found = 1;
                got_addr = bus.imem_addr;
            end
        end
        chk("resume.seen", 32'(found), 32'd1);
        chk("resume.addr", got_addr, 32'h8);

        // slow memory: request held for five cycles
        for (int i = 0; i < 5; i++) begin
            cyc("slow", 0, 32'h0, 0, 1);
            #1;
            chk("slow.req", 32'(bus.imem_req), 32'd1);
            chk("slow.addr", bus.imem_addr, 32'h8);
            chk("slow.valid", 32'(bus.instr_valid), 32'd0);
        end
        cyc("slow", 0, 32'h0, 1, 1);
        #1;
        chk("slow.pc", bus.instr_pc, 32'h8);

        // redirect while waiting on 0x8
        do_reset();
        found = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            cyc("pre", 0, 32'h0, 1, 1);
            #1;
            if (bus.imem_req && bus.imem_addr == 32'h8) found = 1;
        end
        chk("drop.wait8", 32'(found), 32'd1);
        cyc("drop", 1, 32'h40, 0, 1);
        #1;
        chk("drop.req", 32'(bus.imem_req), 32'd1);
        chk("drop.addr", bus.imem_addr, 32'h40);
        chk("drop.valid", 32'(bus.instr_valid), 32'd0);
        cyc("drop", 0, 32'h0, 1, 1);
        found = 0;
        got_addr = 32'hDEAD_BEEF;
        for (int i = 0; i < 8 && !found; i++) begin
            cyc("post", 0, 32'h0, 1, 1);
            #1;
            if (bus.instr_valid) begin
                found = 1;
                got_addr = bus.instr_pc;
            end
        end
        chk("drop.next", got_addr, 32'h40);

        // redirect with a full buffer
        do_reset();
        for (int i = 0; i < 6; i++) cyc("fill", 0, 32'h0, 1, 0);
        #1;
        chk("flush.pre", 32'(bus.instr_valid), 32'd1);
        cyc("flush", 1, 32'h103, 0, 0);
        #1;
        chk("flush.valid", 32'(bus.instr_valid), 32'd0);
        chk("flush.addr", bus.imem_addr, 32'h100);
        cyc("flush", 0, 32'h0, 0, 0);
        #1;
        chk("flush.req", 32'(bus.imem_req), 32'd1);
        chk("flush.addr2", bus.imem_addr, 32'h100);

        // randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++)
            cyc("rnd", ($urandom_range(0, 99) < 5), $urandom, 2,
                ($urandom_range(0, 99) < 60));

        // wrap from the top of the address space, then mid-fetch reset
        @(negedge clk);
        rst_n2 = 1'b1;
        seen.delete();
        for (int i = 0; i < 6; i++) begin
            d2cyc(1, 1);
            if (bus2.instr_valid) begin
                seen.push_back(bus2.instr_pc);
                chk("wrap.word", bus2.instr, word(bus2.instr_pc));
            end
        end
        chk("wrap.n", 32'(seen.size() >= 2), 32'd1);
        if (seen.size() >= 2) begin
            chk("wrap.pc0", seen[0], 32'hFFFF_FFFC);
            chk("wrap.pc1", seen[1], 32'h0000_0000);
        end
        found = 0;
        for (int i = 0; i < 4 && !found; i++) begin
            d2cyc(0, 1);
            if (bus2.imem_req) found = 1;
        end
        chk("arst.wait", 32'(found), 32'd1);
        #2;
        rst_n2 = 1'b0;
        #1;
        chk("arst.req", 32'(bus2.imem_req), 32'd0);
        chk("arst.valid", 32'(bus2.instr_valid), 32'd0);
        chk("arst.instr", bus2.instr, 32'd0);
        chk("arst.pc", bus2.instr_pc, 32'd0);
        chk("arst.addr", bus2.imem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        rst_n2 = 1'b1;
        @(posedge clk);
        #1;
        chk("arst.refetch", 32'(bus2.imem_req), 32'd1);
        chk("arst.readdr", bus2.imem_addr, 32'hFFFF_FFFC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
